// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory/writeback stage with a variable-latency req/ack data port, sized loads/stores, misalignment and timeout detection
// Ports: clk/rst (async active-low); ex_* handshake and EX fields in; dmem_* request/ack port; writeback trio to fetch; misalign_err/timeout_err pulses.
module mem_wb_stage #(
  parameter int ADDR_W         = 32,
  parameter int REG_ID_W       = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [31:0]         alu_result,
  input  logic                write_to_regfile_from_ex,
  input  logic                mem_read_from_ex,
  input  logic                mem_write_from_ex,
  input  logic                mem_to_reg_from_ex,
  input  logic [1:0]          mem_size_from_ex,
  input  logic                mem_unsigned_from_ex,
  input  logic [31:0]         mem_write_data_from_ex,
  input  logic [REG_ID_W-1:0] writeback_reg_id_from_ex,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [3:0]          dmem_be,
  output logic [31:0]         dmem_wdata,
  input  logic                dmem_ack,
  input  logic [31:0]         dmem_rdata,
  output logic                write_to_regfile_to_fetch,
  output logic [31:0]         write_data_to_fetch,
  output logic [REG_ID_W-1:0] writeback_reg_id_to_fetch,
  output logic                misalign_err,
  output logic                timeout_err
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nxt;
  logic [CW-1:0]       cnt;
  logic [31:0]         l_alu;
  logic [1:0]          l_size;
  logic                l_uns, l_to_reg, l_wr;
  logic [REG_ID_W-1:0] l_id;
  logic [1:0]          a;
  logic                mem_op, misal, timeout_hit;
  logic [3:0]          be_nxt;
  logic [31:0]         wdata_nxt, lane, ld, wb_data;
  assign a           = alu_result[1:0];
  assign mem_op      = mem_read_from_ex | mem_write_from_ex;
  assign misal       = (mem_size_from_ex == 2'b01 && a[0]) || (mem_size_from_ex[1] && a != 2'b00);
  assign timeout_hit = TIMEOUT_CYCLES != 0 && !dmem_ack && cnt == CW'(TIMEOUT_CYCLES - 1);
  assign ex_ready    = state == IDLE;
  always_comb begin
    be_nxt    = mem_size_from_ex == 2'b00 ? 4'b0001 << a :
                mem_size_from_ex == 2'b01 ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    wdata_nxt = mem_size_from_ex == 2'b00 ? {4{mem_write_data_from_ex[7:0]}} :
                mem_size_from_ex == 2'b01 ? {2{mem_write_data_from_ex[15:0]}} : mem_write_data_from_ex;
    lane      = dmem_rdata >> {l_alu[1:0], 3'b000};
    ld        = l_size == 2'b00 ? {{24{~l_uns & lane[7]}}, lane[7:0]} :
                l_size == 2'b01 ? {{16{~l_uns & lane[15]}}, lane[15:0]} : lane;
    wb_data   = (!dmem_we && l_to_reg) ? ld : l_alu;
  end
  always_comb begin
    state_nxt = state == IDLE ? ((ex_valid && mem_op && !misal) ? ACCESS : IDLE)
                              : ((dmem_ack || timeout_hit) ? IDLE : ACCESS);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt                       <= '0;
      l_alu                     <= '0;
      l_size                    <= '0;
      l_uns                     <= 1'b0;
      l_to_reg                  <= 1'b0;
      l_wr                      <= 1'b0;
      l_id                      <= '0;
      dmem_req                  <= 1'b0;
      dmem_we                   <= 1'b0;
      dmem_addr                 <= '0;
      dmem_be                   <= '0;
      dmem_wdata                <= '0;
      write_to_regfile_to_fetch <= 1'b0;
      write_data_to_fetch       <= '0;
      writeback_reg_id_to_fetch <= '0;
      misalign_err              <= 1'b0;
      timeout_err               <= 1'b0;
    end else begin
      write_to_regfile_to_fetch <= 1'b0;
      misalign_err              <= 1'b0;
      timeout_err               <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid && !mem_op) begin
          write_to_regfile_to_fetch <= write_to_regfile_from_ex;
          write_data_to_fetch       <= alu_result;
          writeback_reg_id_to_fetch <= writeback_reg_id_from_ex;
        end else if (ex_valid && misal) begin
          misalign_err <= 1'b1;
        end else if (ex_valid) begin
          cnt        <= '0;
          l_alu      <= alu_result;
          l_size     <= mem_size_from_ex;
          l_uns      <= mem_unsigned_from_ex;
          l_to_reg   <= mem_to_reg_from_ex;
          l_wr       <= write_to_regfile_from_ex;
          l_id       <= writeback_reg_id_from_ex;
          dmem_req   <= 1'b1;
          dmem_we    <= mem_write_from_ex;
          dmem_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
          dmem_be    <= be_nxt;
          dmem_wdata <= wdata_nxt;
        end
      end else if (dmem_ack) begin
        dmem_req                  <= 1'b0;
        write_to_regfile_to_fetch <= l_wr;
        write_data_to_fetch       <= wb_data;
        writeback_reg_id_to_fetch <= l_id;
      end else if (timeout_hit) begin
        dmem_req    <= 1'b0;
        timeout_err <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] alu_result = '0;
  logic        wr_in = 1'b0, rd_in = 1'b0, we_in = 1'b0, to_reg_in = 1'b0, uns_in = 1'b0;
  logic [1:0]  size_in = '0;
  logic [31:0] wdata_in = '0;
  logic [4:0]  id_in = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        wb_en, misalign_err, timeout_err;
  logic [31:0] wb_data;
  logic [4:0]  wb_id;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_wb_stage #(.ADDR_W(32), .REG_ID_W(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .alu_result(alu_result),
    .write_to_regfile_from_ex(wr_in), .mem_read_from_ex(rd_in), .mem_write_from_ex(we_in),
    .mem_to_reg_from_ex(to_reg_in), .mem_size_from_ex(size_in), .mem_unsigned_from_ex(uns_in),
    .mem_write_data_from_ex(wdata_in), .writeback_reg_id_from_ex(id_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .write_to_regfile_to_fetch(wb_en), .write_data_to_fetch(wb_data),
    .writeback_reg_id_to_fetch(wb_id), .misalign_err(misalign_err), .timeout_err(timeout_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic issue(input logic [31:0] addr, input logic rd, input logic st, input logic to_reg,
                       input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] d,
                       input logic [4:0] id);
    alu_result = addr; rd_in = rd; we_in = st; to_reg_in = to_reg; wr_in = wr;
    size_in = sz; uns_in = uns; wdata_in = d; id_in = id; ex_valid = 1'b1;
    step();
    ex_valid = 1'b0;
  endtask
  task automatic ack_after(input int n, input logic [31:0] rdata);
    for (int i = 0; i < n; i++) begin
      step();
      chk("wait_req", dmem_req, 1'b1);
      chk("wait_ready", ex_ready, 1'b0);
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    step();
    dmem_ack = 1'b0;
  endtask
  initial begin
    #1 rst = 1'b0;
    step();
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_ready", ex_ready, 1'b1);
    chk("rst_wb", wb_en, 1'b0);
    rst = 1'b1;
    step();
    issue(32'h1234, 0, 0, 0, 1, 2'b10, 0, 0, 5'd7);
    chk("alu_wb", wb_en, 1'b1);
    chk("alu_data", wb_data, 32'h1234);
    chk("alu_id", wb_id, 5'd7);
    chk("alu_req", dmem_req, 1'b0);
    step();
    chk("alu_pulse", wb_en, 1'b0);
    issue(32'h103, 1, 0, 1, 1, 2'b00, 0, 0, 5'd3);
    chk("sb_req", dmem_req, 1'b1);
    chk("sb_we", dmem_we, 1'b0);
    chk("sb_be", dmem_be, 4'b1000);
    chk("sb_addr", dmem_addr, 32'h100);
    chk("sb_ready", ex_ready, 1'b0);
    ack_after(2, 32'h80AABBCC);
    chk("sb_wb", wb_en, 1'b1);
    chk("sb_data", wb_data, 32'hFFFFFF80);
    chk("sb_id", wb_id, 5'd3);
    chk("sb_req_off", dmem_req, 1'b0);
    chk("sb_ready_on", ex_ready, 1'b1);
    issue(32'h103, 1, 0, 1, 1, 2'b00, 1, 0, 5'd4);
    ack_after(2, 32'h80AABBCC);
    chk("ub_data", wb_data, 32'h00000080);
    chk("ub_wb", wb_en, 1'b1);
    issue(32'h22, 0, 1, 0, 0, 2'b01, 0, 32'h0000BEEF, 5'd5);
    chk("sh_we", dmem_we, 1'b1);
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
    chk("sh_addr", dmem_addr, 32'h20);
    alu_result = 32'h55; rd_in = 0; we_in = 0; wr_in = 1; ex_valid = 1'b1;
    step();
    chk("sh_ignore_ex", wb_en, 1'b0);
    chk("sh_hold_addr", dmem_addr, 32'h20);
    chk("sh_hold_wdata", dmem_wdata, 32'hBEEFBEEF);
    ex_valid = 1'b0;
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("sh_done_req", dmem_req, 1'b0);
    chk("sh_no_wb", wb_en, 1'b0);
    issue(32'h2, 1, 0, 1, 1, 2'b10, 0, 0, 5'd6);
    chk("mw_err", misalign_err, 1'b1);
    chk("mw_req", dmem_req, 1'b0);
    chk("mw_wb", wb_en, 1'b0);
    chk("mw_ready", ex_ready, 1'b1);
    step();
    chk("mw_pulse", misalign_err, 1'b0);
    issue(32'h1, 1, 0, 1, 1, 2'b01, 0, 0, 5'd6);
    chk("mh_err", misalign_err, 1'b1);
    chk("mh_req", dmem_req, 1'b0);
    chk("mh_wb", wb_en, 1'b0);
    issue(32'h40, 1, 0, 1, 1, 2'b10, 0, 0, 5'd8);
    chk("to_req0", dmem_req, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("to_req_hold", dmem_req, 1'b1);
    end
    step();
    chk("to_req_drop", dmem_req, 1'b0);
    chk("to_err", timeout_err, 1'b1);
    chk("to_no_wb", wb_en, 1'b0);
    chk("to_ready", ex_ready, 1'b1);
    issue(32'hABC, 0, 0, 0, 1, 2'b10, 0, 0, 5'd2);
    chk("to_next_wb", wb_en, 1'b1);
    chk("to_next_data", wb_data, 32'hABC);
    chk("to_err_pulse", timeout_err, 1'b0);
    issue(32'h44, 1, 0, 1, 1, 2'b10, 0, 0, 5'd9);
    ack_after(3, 32'hDEADBEEF);
    chk("late_ack_wb", wb_en, 1'b1);
    chk("late_ack_data", wb_data, 32'hDEADBEEF);
    chk("late_ack_noerr", timeout_err, 1'b0);
    issue(32'h48, 1, 0, 1, 1, 2'b10, 0, 0, 5'd10);
    step();
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", dmem_req, 1'b0);
    chk("mid_rst_ready", ex_ready, 1'b1);
    chk("mid_rst_be", dmem_be, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    step();
    dmem_ack = 1'b0;
    chk("post_rst_wb", wb_en, 1'b0);
    chk("post_rst_req", dmem_req, 1'b0);
    chk("post_rst_terr", timeout_err, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
